frame_wr_mod: RTL
=================

// Module: frame_wr_mod
// PURPOSE
//  Writer end of the pixel block-RAM interface: stores one processed frame (Sobel edge magnitude)
//  into a single-port BRAM, one byte per pixel at sequential addresses 0..FRAME_PIXELS-1.
//  Accepts a valid/ready pixel stream with start-of-frame marker; drives BRAM ena/wea/addr/din.
//  Sits between the edge-detection datapath and the output frame buffer read by display/readback logic.
// PARAMETERS
//  ADDR_W        15     BRAM address width
//  DATA_W        8      pixel width
//  FRAME_PIXELS  19211  pixels per frame (addresses 0..19210); must be <= 2**ADDR_W
// PORTS
//  sys_clk_i      in   1       clock, all logic on rising edge
//  sys_rst_i      in   1       synchronous reset, active-high
//  start_i        in   1       1-cycle pulse: arm capture of next frame
//  pix_valid_i    in   1       input beat valid
//  pix_sof_i      in   1       beat is first pixel of frame (qualified by pix_valid_i)
//  pix_data_i     in   DATA_W  pixel value
//  pix_ready_o    out  1       writer accepts beat this cycle (beat transfers when valid&ready)
//  mem_ena_o      out  1       BRAM enable
//  mem_wea_o      out  1       BRAM write enable
//  mem_addr_o     out  ADDR_W  BRAM address
//  mem_din_o      out  DATA_W  BRAM write data
//  busy_o         out  1       high in ARMED or WRITE
//  frame_done_o   out  1       high in DONE (full frame stored)
//  pix_count_o    out  ADDR_W  pixels written in current frame
//  err_sync_o     out  1       sticky: sof seen mid-frame
// BEHAVIOUR
//  Reset (sync): state IDLE; all outputs 0; pix_count 0; err_sync 0. Reset wins over all inputs.
//  States: IDLE, ARMED, WRITE, DONE.
//   IDLE : ready=0. start_i -> ARMED.
//   ARMED: ready=1. Beat without sof: accepted and discarded. Beat with sof: write addr 0, -> WRITE.
//   WRITE: ready=1. Each beat written to addr = pix_count, pix_count+1.
//          Beat with sof in WRITE: err_sync<=1, written to addr 0, pix_count<=1 (frame restarts).
//          Beat at addr FRAME_PIXELS-1 -> DONE after write. start_i ignored.
//   DONE : ready=0, frame_done_o=1 held. start_i -> ARMED, frame_done_o cleared,
//          pix_count cleared, err_sync cleared.
//  pix_ready_o is a registered function of state only (no combinational path from pix_valid_i).
//  Write latency: beat accepted at edge N -> mem_ena_o=mem_wea_o=1 with addr/data for cycle after N
//   (registered, exactly 1 cycle); mem_ena_o/mem_wea_o 0 on cycles with no accepted-and-stored beat.
//  Discarded beats (ARMED, no sof) never assert mem_wea_o.
//  Address never exceeds FRAME_PIXELS-1; no wrap; last-beat transition and write occur same edge.
//  pix_count_o updates on the edge the beat is accepted; equals FRAME_PIXELS in DONE.
//  start_i together with sof beat in IDLE: start processed, beat not accepted (ready was 0).
//  Reset mid-WRITE: next cycle mem_wea_o=0, IDLE; partial frame abandoned.
// TESTING
//  1 reset, start, 19211 beats (sof on 1st, data=addr[7:0]) -> writes addr 0..19210 correct data,
//    frame_done_o=1 cycle after last write, pix_count_o=19211, ready=0 afterwards.
//  2 ARMED, 5 beats no sof then sof beat data 0xAA -> no writes for 5, addr 0 gets 0xAA.
//  3 random pix_valid_i gaps (50%) over full frame -> contiguous addresses, no write on idle cycles.
//  4 sof at pixel 100 mid-frame -> err_sync_o=1, that pixel written addr 0, pix_count_o=1; completes.
//  5 sys_rst_i at pixel 500 -> next cycle all outputs 0, IDLE; beats ignored until start_i.
//  6 DONE, start_i -> ARMED, frame_done_o=0, err_sync_o=0; second full frame stored correctly.

Source files
------------

// File: rtl/frame_wr_mod.sv
// frame_wr_mod: stores one processed frame into a single-port BRAM, one byte
// per pixel at sequential addresses 0..FRAME_PIXELS-1. Accepts a valid/ready
// pixel stream carrying a start-of-frame marker and drives registered BRAM
// ena/wea/addr/din with exactly one cycle of write latency.
module frame_wr_mod #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 19211  // must be <= 2**ADDR_W
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              start_i,
  input  logic              pix_valid_i,
  input  logic              pix_sof_i,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic              pix_ready_o,
  output logic              mem_ena_o,
  output logic              mem_wea_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [ADDR_W-1:0] pix_count_o,
  output logic              err_sync_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pix_count;
  logic [ADDR_W-1:0]   w_count_next;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                r_err_sync;
  logic                w_err_next;
  logic                w_wr_en;
  logic                w_accept;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;

  // A beat transfers only when the registered ready is already high, so there
  // is no combinational path from pix_valid_i to pix_ready_o.
  assign w_accept = pix_valid_i & r_ready;

  // Next-state, next-count and write-request decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_count_next = r_pix_count;
    w_err_next   = r_err_sync;
    w_wr_en      = 1'b0;
    w_wr_addr    = '0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        // Arming a new capture clears the previous frame's status.
        if (start_i) begin
          w_next_state = S_ARMED;
          w_count_next = '0;
          w_err_next   = 1'b0;
        end
      end
      S_ARMED: begin
        // Beats without sof are accepted and dropped until the frame starts.
        if (w_accept && pix_sof_i) begin
          w_wr_en      = 1'b1;
          w_wr_addr    = '0;
          w_count_next = ADDR_W'(1);
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (pix_sof_i) begin
            // Resynchronise: restart the frame at address 0 and flag it.
            w_wr_addr    = '0;
            w_count_next = ADDR_W'(1);
            w_err_next   = 1'b1;
          end else begin
            w_wr_addr    = r_pix_count;
            w_count_next = r_pix_count + 1'b1;
            if (r_pix_count == LAST_ADDR) begin
              w_next_state = S_DONE;
            end
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, status and BRAM port registers; reset has priority over everything.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state     <= S_IDLE;
      r_pix_count <= '0;
      r_err_sync  <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      r_state     <= w_next_state;
      r_pix_count <= w_count_next;
      r_err_sync  <= w_err_next;
      r_ready     <= (w_next_state == S_ARMED) || (w_next_state == S_WRITE);
      r_busy      <= (w_next_state == S_ARMED) || (w_next_state == S_WRITE);
      r_done      <= (w_next_state == S_DONE);
      r_mem_we    <= w_wr_en;
      if (w_wr_en) begin
        r_mem_addr <= w_wr_addr;
        r_mem_din  <= pix_data_i;
      end
    end
  end

  assign pix_ready_o  = r_ready;
  assign mem_ena_o    = r_mem_we;
  assign mem_wea_o    = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_din_o    = r_mem_din;
  assign busy_o       = r_busy;
  assign frame_done_o = r_done;
  assign pix_count_o  = r_pix_count;
  assign err_sync_o   = r_err_sync;

endmodule
